// File: rtl/four_phase_pkg.sv
// Shared constants for four_phase_pipe: bit positions of the proto_err flags
// and the width helper for the tokens count.
package four_phase_pkg;

  localparam int ERR_REQ_DROP      = 0;
  localparam int ERR_DATA_UNSTABLE = 1;
  localparam int ERR_ACK_EARLY     = 2;
  localparam int ERR_ACK_DROP      = 3;

  // Enough bits to count 0..depth occupied stages.
  function automatic int tokens_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/four_phase_pipe_c_element_reg.sv
// Registered Muller C-element: follows f when f disagrees with b, otherwise
// holds. The caller feeds b from the next stage, which gives the inverted ack.
module c_element_reg (
  input  logic clk,
  input  logic rst,
  input  logic f,
  input  logic b,
  output logic c
);

  logic c_q;
  logic c_d;

  always_comb begin
    c_d = c_q;
    if (f == ~b) c_d = f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_q <= 1'b0;
    else     c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: rtl/four_phase_pipe.sv
// Clocked DEPTH-stage four-phase bundled-data micropipeline.
// Optional protocol checker: define FOUR_PHASE_PIPE_PROTO_CHECK_EN.
module four_phase_pipe
  import four_phase_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_req,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ack,
  output logic                           out_req,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ack,
  output logic [tokens_width(DEPTH)-1:0] tokens,
  output logic [3:0]                     proto_err
);

  localparam int TW = tokens_width(DEPTH);

  // Handshake: both ends are four-phase. A side raises req with data stable,
  // the other side raises ack, req returns to 0, then ack returns to 0.
  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] f;
  logic [DEPTH-1:0] b;
  logic [DEPTH-1:0] ld;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [TW-1:0]    tok_sum;

  assign f  = {c[DEPTH-2:0], in_req};
  assign b  = {out_ack, c[DEPTH-1:1]};
  assign ld = ~c & f & ~b;  // edges on which c[i] will go 0->1

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    c_element_reg u_c (
      .clk (clk),
      .rst (rst),
      .f   (f[i]),
      .b   (b[i]),
      .c   (c[i])
    );
  end

  always_comb begin
    d_d[0] = ld[0] ? in_data : d_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      d_d[i] = ld[i] ? d_q[i-1] : d_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  // A stage holds an unreleased datum while its successor has not yet taken it.
  always_comb begin
    tok_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tok_sum = tok_sum + TW'(c[i] & ~b[i]);
    end
  end

  assign in_ack   = c[0];
  assign out_req  = c[DEPTH-1];
  assign out_data = d_q[DEPTH-1];
  assign tokens   = tok_sum;

`ifdef FOUR_PHASE_PIPE_PROTO_CHECK_EN
  logic             req_in_q;
  logic             ack_out_q;
  logic [WIDTH-1:0] data_in_q;
  logic [3:0]       err_q;
  logic [3:0]       err_d;

  // Each rule compares this edge's inputs with those sampled on the previous edge.
  always_comb begin
    err_d = err_q;
    if (req_in_q && !in_req && !c[0])
      err_d[ERR_REQ_DROP] = 1'b1;
    if (req_in_q && in_req && !c[0] && (in_data != data_in_q))
      err_d[ERR_DATA_UNSTABLE] = 1'b1;
    if (!ack_out_q && out_ack && !c[DEPTH-1])
      err_d[ERR_ACK_EARLY] = 1'b1;
    if (ack_out_q && !out_ack && c[DEPTH-1])
      err_d[ERR_ACK_DROP] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_in_q  <= 1'b0;
      ack_out_q <= 1'b0;
      data_in_q <= '0;
      err_q     <= 4'b0;
    end else begin
      req_in_q  <= in_req;
      ack_out_q <= out_ack;
      data_in_q <= in_data;
      err_q     <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 4'b0;
`endif

endmodule
